// File: rtl/msrv32_pkg.sv
// Shared types and constants for the data-memory arbiter.
package msrv32_pkg;

  localparam int unsigned REQ_ID_W = 1;
  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } dmem_state_e;

  // Transfer attributes captured at grant time.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } xfer_t;

endpackage

// File: rtl/msrv32_dmem_rr_picker.sv
// Two-way requester pick; round-robin pointer only when MSRV32_DMEM_RR_EN is defined,
// otherwise fixed priority to requester 0.
module msrv32_dmem_rr_picker
  import msrv32_pkg::*;
(
`ifdef MSRV32_DMEM_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
`endif
  input  logic [1:0] req,
  output logic       any,
  output req_id_t    win
);

  assign any = |req;

`ifdef MSRV32_DMEM_RR_EN
  // prio_q names the requester that wins a tie; it moves away from each winner.
  req_id_t prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= '0;
    end else if (adv && any) begin
      prio_q <= ~win;
    end
  end

  always_comb begin
    win = '0;
    if (req == 2'b11) begin
      win = prio_q;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end
`else
  assign win = req_id_t'(req[1] && !req[0]);
`endif

endmodule

// File: rtl/msrv32_dmem_arbiter.sv
// Two-requester data-memory arbiter driving a single AHB-style address/data bus.
// Build option: MSRV32_DMEM_RR_EN selects round-robin instead of fixed r0 priority.
module msrv32_dmem_arbiter #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        r0_req_in,
  input  logic        r0_wr_in,
  input  logic [31:0] r0_addr_in,
  input  logic [31:0] r0_wdata_in,
  input  logic [3:0]  r0_mask_in,
  output logic        r0_gnt_out,
  output logic        r0_done_out,
  output logic        r0_err_out,
  output logic [31:0] r0_rdata_out,
  input  logic        r1_req_in,
  input  logic        r1_wr_in,
  input  logic [31:0] r1_addr_in,
  input  logic [31:0] r1_wdata_in,
  input  logic [3:0]  r1_mask_in,
  output logic        r1_gnt_out,
  output logic        r1_done_out,
  output logic        r1_err_out,
  output logic [31:0] r1_rdata_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out,
  input  logic        ahb_ready_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in
);
  import msrv32_pkg::*;

  localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_TIMEOUT);

  dmem_state_e state_q, state_d;
  xfer_t       lat_q, lat_d;
  req_id_t     owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  gnt, done_q, err_q;
  logic [1:0][31:0] rdata_q;
  logic        fin_ok, fin_err, any_req;
  req_id_t     win_id;

  msrv32_dmem_rr_picker u_picker (
`ifdef MSRV32_DMEM_RR_EN
    .clk   (ms_riscv32_mp_clk_in),
    .rst_n (ms_riscv32_mp_rst_n_in),
    .adv   (state_q == StIdle),
`endif
    .req   ({r1_req_in, r0_req_in}),
    .any   (any_req),
    .win   (win_id)
  );

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt      = '0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    ms_riscv32_mp_dmaddr_out    = '0;
    ms_riscv32_mp_dmdata_out    = '0;
    ms_riscv32_mp_dmwr_mask_out = '0;
    ms_riscv32_mp_dmwr_req_out  = 1'b0;
    ahb_htrans_out              = HTRANS_IDLE;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt[win_id] = 1'b1;
          owner_d     = win_id;
          cnt_d       = '0;
          state_d     = StAddr;
          lat_d = win_id ? '{wr: r1_wr_in, addr: r1_addr_in, wdata: r1_wdata_in, mask: r1_mask_in}
                         : '{wr: r0_wr_in, addr: r0_addr_in, wdata: r0_wdata_in, mask: r0_mask_in};
        end
      end
      StAddr: begin
        ahb_htrans_out           = HTRANS_NONSEQ;
        ms_riscv32_mp_dmaddr_out = lat_q.addr;
        if (ahb_ready_in) begin
          state_d = StData;
        end
      end
      StData: begin
        if (lat_q.wr) begin
          ms_riscv32_mp_dmdata_out    = lat_q.wdata;
          ms_riscv32_mp_dmwr_mask_out = lat_q.mask;
          ms_riscv32_mp_dmwr_req_out  = 1'b1;
        end
        if (ahb_ready_in) begin
          fin_ok  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Stall accounting shared by both bus phases; reaching the limit aborts the transfer.
    if (state_q != StIdle && !ahb_ready_in) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_inc;
      end
      if (cnt_q == CntMax || cnt_inc == CntMax) begin
        fin_err = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= StIdle;
      lat_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      done_q  <= '0;
      err_q   <= '0;
      if (fin_ok || fin_err) begin
        done_q[owner_q] <= 1'b1;
        err_q[owner_q]  <= fin_err;
      end
      if (fin_ok && !lat_q.wr) begin
        rdata_q[owner_q] <= ms_riscv32_mp_dmdata_in;
      end
    end
  end

  assign r0_gnt_out   = gnt[0];
  assign r1_gnt_out   = gnt[1];
  assign r0_done_out  = done_q[0];
  assign r1_done_out  = done_q[1];
  assign r0_err_out   = err_q[0];
  assign r1_err_out   = err_q[1];
  assign r0_rdata_out = rdata_q[0];
  assign r1_rdata_out = rdata_q[1];

endmodule

// File: tb/tb_msrv32_dmem_arbiter.sv
// Self-checking bench for msrv32_dmem_arbiter against a cycle-count transaction model.
module tb_msrv32_dmem_arbiter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_wr, r0_gnt, r0_done, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [3:0]  r0_mask;
  logic        r1_req, r1_wr, r1_gnt, r1_done, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [3:0]  r1_mask;
  logic [31:0] dmaddr, dmdata_o, dmdata_i;
  logic [3:0]  wmask;
  logic        wreq, ready;
  logic [1:0]  htrans;

  int checks = 0;
  int errors = 0;
  logic [31:0] rmodel [2];

  always #5 clk = ~clk;

  msrv32_dmem_arbiter #(.WAIT_TIMEOUT(T)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst_n),
    .r0_req_in                   (r0_req),
    .r0_wr_in                    (r0_wr),
    .r0_addr_in                  (r0_addr),
    .r0_wdata_in                 (r0_wdata),
    .r0_mask_in                  (r0_mask),
    .r0_gnt_out                  (r0_gnt),
    .r0_done_out                 (r0_done),
    .r0_err_out                  (r0_err),
    .r0_rdata_out                (r0_rdata),
    .r1_req_in                   (r1_req),
    .r1_wr_in                    (r1_wr),
    .r1_addr_in                  (r1_addr),
    .r1_wdata_in                 (r1_wdata),
    .r1_mask_in                  (r1_mask),
    .r1_gnt_out                  (r1_gnt),
    .r1_done_out                 (r1_done),
    .r1_err_out                  (r1_err),
    .r1_rdata_out                (r1_rdata),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmdata_out    (dmdata_o),
    .ms_riscv32_mp_dmwr_mask_out (wmask),
    .ms_riscv32_mp_dmwr_req_out  (wreq),
    .ahb_htrans_out              (htrans),
    .ahb_ready_in                (ready),
    .ms_riscv32_mp_dmdata_in     (dmdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    if (id == 0) begin
      r0_req = req; r0_wr = wr; r0_addr = addr; r0_wdata = wdata; r0_mask = mask;
    end else begin
      r1_req = req; r1_wr = wr; r1_addr = addr; r1_wdata = wdata; r1_mask = mask;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"}, {30'd0, r1_gnt, r0_gnt}, 32'd0);
    chk({tag, " done"}, {30'd0, r1_done, r0_done}, 32'd0);
    chk({tag, " err"}, {30'd0, r1_err, r0_err}, 32'd0);
    chk({tag, " rdata0"}, r0_rdata, 32'd0);
    chk({tag, " rdata1"}, r1_rdata, 32'd0);
    chk({tag, " addr"}, dmaddr, 32'd0);
    chk({tag, " wdata"}, dmdata_o, 32'd0);
    chk({tag, " bus ctl"}, {25'd0, wmask, wreq, htrans}, 32'd0);
  endtask

  // Bus ready level for cycle c after grant, given stalls in the address and data phases.
  function automatic logic rdy_for(input int c, input int sa, input int sd);
    if (c <= sa) return 1'b0;
    if (c == sa + 1) return 1'b1;
    return (c - sa - 2) >= sd;
  endfunction

  // Starts and ends one cycle after a rising edge with the arbiter idle and no requests.
  task automatic xfer(input string tag, input int id, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask, input int sa,
                      input int sd, input logic [31:0] rd);
    bit to;
    int done_c;
    to     = (sa + sd) >= T;
    done_c = to ? ((T <= sa) ? T + 1 : T + 2) : 3 + sa + sd;
    set_req(id, 1'b1, wr, addr, wdata, mask);
    dmdata_i = rd;
    ready    = 1'b1;
    @(negedge clk);
    chk({tag, " gnt c0"}, {30'd0, r1_gnt, r0_gnt}, 32'd1 << id);
    for (int c = 1; c < done_c; c++) begin
      @(posedge clk); #1;
      if (id == 0) r0_req = 1'b0; else r1_req = 1'b0;
      ready = rdy_for(c, sa, sd);
      @(negedge clk);
      chk({tag, " mid gnt/done"}, {28'd0, r1_gnt, r0_gnt, r1_done, r0_done}, 32'd0);
      if (c <= sa + 1) begin
        chk({tag, " addr-phase htrans"}, {30'd0, htrans}, 32'd2);
        chk({tag, " addr-phase addr"}, dmaddr, addr);
        chk({tag, " addr-phase wr"}, {27'd0, wmask, wreq}, 32'd0);
      end else begin
        chk({tag, " data-phase htrans"}, {30'd0, htrans}, 32'd0);
        chk({tag, " data-phase addr"}, dmaddr, 32'd0);
        chk({tag, " data-phase wdata"}, dmdata_o, wr ? wdata : 32'd0);
        chk({tag, " data-phase wr"}, {27'd0, wmask, wreq}, wr ? {27'd0, mask, 1'b1} : 32'd0);
      end
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    if (!wr && !to) rmodel[id] = rd;
    chk({tag, " done"}, {30'd0, r1_done, r0_done}, 32'd1 << id);
    chk({tag, " err"}, {30'd0, r1_err, r0_err}, to ? (32'd1 << id) : 32'd0);
    chk({tag, " rdata0"}, r0_rdata, rmodel[0]);
    chk({tag, " rdata1"}, r1_rdata, rmodel[1]);
    chk({tag, " done-cycle bus"}, {30'd0, htrans}, 32'd0);
    chk({tag, " done-cycle gnt"}, {30'd0, r1_gnt, r0_gnt}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] g, d;
    bit rr;
    int exp_id;
`ifdef MSRV32_DMEM_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rmodel[0] = '0;
    rmodel[1] = '0;
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    ready    = 1'b1;
    dmdata_i = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters held high: grants every third cycle, each in the previous done cycle.
    set_req(0, 1'b1, 1'b0, 32'h0000_0040, '0, '0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0080, '0, '0);
    dmdata_i = 32'hA5A5_0001;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      g = {30'd0, r1_gnt, r0_gnt};
      d = {30'd0, r1_done, r0_done};
      exp_id = rr ? (k / 3) % 2 : 0;
      chk("arb gnt", g, (k % 3 == 0 && k <= 9) ? (32'd1 << exp_id) : 32'd0);
      exp_id = rr ? (k / 3 - 1) % 2 : 0;
      chk("arb done", d, (k % 3 == 0 && k >= 3) ? (32'd1 << exp_id) : 32'd0);
      if (k % 3 == 0 && k >= 3) rmodel[exp_id] = dmdata_i;
      @(posedge clk); #1;
      if (k == 9) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
    end
    chk("arb rdata0", r0_rdata, rmodel[0]);
    chk("arb rdata1", r1_rdata, rmodel[1]);

    xfer("r0 read", 0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
    xfer("r1 write", 1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 0, 2, 32'h5555_5555);
    xfer("timeout addr", 0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 10, 0, 32'h1111_1111);
    xfer("timeout data", 1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 10, 32'h2222_2222);

    for (int n = 0; n < 20; n++) begin
      xfer("rand", int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           {$urandom_range(32'h3FFF_FFFF, 0), 2'b00}, $urandom, 4'($urandom_range(15, 0)),
           int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom);
    end

    // Reset asserted while a write sits in its data phase.
    set_req(1, 1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF);
    ready = 1'b1;
    @(negedge clk);
    chk("rst-mid gnt", {30'd0, r1_gnt, r0_gnt}, 32'd2);
    @(posedge clk); #1;
    r1_req = 1'b0;
    @(posedge clk); #1;
    chk("rst-mid wreq before", {31'd0, wreq}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    rmodel[0] = '0;
    rmodel[1] = '0;
    chk_all_zero("rst-mid");
    @(posedge clk); #1;
    chk_all_zero("rst-hold");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-rst no done", {30'd0, r1_done, r0_done}, 32'd0);
      @(posedge clk); #1;
    end
    xfer("post-rst read", 0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1, 1, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
